// File: rtl/alu_sequencer.sv
// alu_sequencer: command FIFO feeding a registered ALU operand stage with a three-state issue/capture FSM.
module alu_sequencer #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_chain,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_f,
    output logic         alu_x,
    output logic         alu_n,
    input  logic [W-1:0] alu_y,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [2:0]   res_op,
    output logic         busy,
    output logic [7:0]   ops_done
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0] count_q, count_d;
    logic [2:0] op_mem [DEPTH];
    logic [W-1:0] a_mem [DEPTH];
    logic [W-1:0] b_mem [DEPTH];
    logic ch_mem [DEPTH];
    logic [W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, last_q, last_d, res_data_q, res_data_d;
    logic [2:0] alu_op_q, alu_op_d, res_op_q, res_op_d;
    logic res_valid_q, res_valid_d;
    logic [7:0] ops_q, ops_d;
    logic push, pop, exec, ack;

    assign cmd_ready = count_q != (AW+1)'(DEPTH);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state_q == IDLE && count_q != '0;
    assign exec      = state_q == EXEC;
    assign ack       = state_q == DONE && res_ready;
    assign busy      = state_q != IDLE || count_q != '0;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign {alu_f, alu_x, alu_n} = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign ops_done  = ops_q;

    always_comb begin
        state_d     = pop ? EXEC : exec ? DONE : ack ? IDLE : state_q;
        wp_d        = push ? wp_q + 1'b1 : wp_q;
        rp_d        = pop ? rp_q + 1'b1 : rp_q;
        count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
        // chained commands take operand A from the most recent captured result
        alu_a_d     = pop ? (ch_mem[rp_q] ? last_q : a_mem[rp_q]) : alu_a_q;
        alu_b_d     = pop ? b_mem[rp_q] : alu_b_q;
        alu_op_d    = pop ? op_mem[rp_q] : alu_op_q;
        res_valid_d = exec ? 1'b1 : ack ? 1'b0 : res_valid_q;
        res_data_d  = exec ? alu_y : res_data_q;
        last_d      = exec ? alu_y : last_q;
        res_op_d    = exec ? alu_op_q : res_op_q;
        ops_d       = exec ? ops_q + 8'd1 : ops_q;
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            op_mem[wp_q] <= cmd_op;
            a_mem[wp_q]  <= cmd_a;
            b_mem[wp_q]  <= cmd_b;
            ch_mem[wp_q] <= cmd_chain;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            last_q      <= '0;
            res_op_q    <= '0;
            ops_q       <= '0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            last_q      <= last_d;
            res_op_q    <= res_op_d;
            ops_q       <= ops_d;
        end
    end
endmodule
